// File: rtl/decode_stage.sv
// MIPS instruction decode stage: register file, control decode, immediate
// sign extension, load-use hazard detection and the ID/EX pipeline register.
module decode_stage #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction_if_id,
    input  logic [DATA_W-1:0] pc_plus4_if_id,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_register,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic              flush,
    output logic              stall_if,
    output logic [DATA_W-1:0] read_data_1_id_ex,
    output logic [DATA_W-1:0] read_data_2_id_ex,
    output logic [DATA_W-1:0] extended_branch_offset_id_ex,
    output logic [DATA_W-1:0] supposed_next_address_id_ex,
    output logic [REG_AW-1:0] next_instruction_20_16_id_ex,
    output logic [REG_AW-1:0] next_instruction_15_11_id_ex,
    output logic              ctrl_regDest_id_ex,
    output logic              ctrl_aluSrc_id_ex,
    output logic [1:0]        ctrl_aluOp_id_ex,
    output logic              ctrl_branch_id_ex,
    output logic              ctrl_memRead_id_ex,
    output logic              ctrl_memWrite_id_ex,
    output logic              ctrl_memToReg_id_ex,
    output logic              ctrl_regWrite_id_ex
);
    typedef struct packed {
        logic       reg_dest;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [DATA_W-1:0] rs_data, rt_data, imm_ext;
    logic              wb_active, hazard;
    ctrl_t             ctrl_dec, ctrl_q;

    assign opcode  = instruction_if_id[31:26];
    assign rs      = instruction_if_id[25:21];
    assign rt      = instruction_if_id[20:16];
    assign rd      = instruction_if_id[15:11];
    assign imm_ext = {{(DATA_W-16){instruction_if_id[15]}}, instruction_if_id[15:0]};

    assign wb_active = wb_reg_write && (wb_write_register != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_active) begin
            regs[wb_write_register] <= wb_write_data;
        end
    end

    // Write-before-read: a same-cycle WB result is forwarded straight to the read ports.
    always_comb begin
        rs_data = regs[rs];
        rt_data = regs[rt];
        if (rs == '0)                                 rs_data = '0;
        else if (wb_active && wb_write_register == rs) rs_data = wb_write_data;
        if (rt == '0)                                 rt_data = '0;
        else if (wb_active && wb_write_register == rt) rt_data = wb_write_data;
    end

    always_comb begin
        ctrl_dec = '0;
        case (opcode)
            OP_RTYPE: ctrl_dec = '{reg_dest: 1'b1, alu_src: 1'b0, alu_op: 2'b10, branch: 1'b0,
                                   mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b1};
            OP_LW:    ctrl_dec = '{reg_dest: 1'b0, alu_src: 1'b1, alu_op: 2'b00, branch: 1'b0,
                                   mem_read: 1'b1, mem_write: 1'b0, mem_to_reg: 1'b1, reg_write: 1'b1};
            OP_SW:    ctrl_dec = '{reg_dest: 1'b0, alu_src: 1'b1, alu_op: 2'b00, branch: 1'b0,
                                   mem_read: 1'b0, mem_write: 1'b1, mem_to_reg: 1'b0, reg_write: 1'b0};
            OP_BEQ:   ctrl_dec = '{reg_dest: 1'b0, alu_src: 1'b0, alu_op: 2'b01, branch: 1'b1,
                                   mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0};
            OP_ADDI:  ctrl_dec = '{reg_dest: 1'b0, alu_src: 1'b1, alu_op: 2'b00, branch: 1'b0,
                                   mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b1};
            default:  ctrl_dec = '0;
        endcase
    end

    assign hazard = ctrl_q.mem_read && (next_instruction_20_16_id_ex != '0) &&
                    (next_instruction_20_16_id_ex == rs || next_instruction_20_16_id_ex == rt);
    assign stall_if = hazard;

    // Data fields load every cycle; only control is squashed on flush or hazard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q                       <= '0;
            read_data_1_id_ex            <= '0;
            read_data_2_id_ex            <= '0;
            extended_branch_offset_id_ex <= '0;
            supposed_next_address_id_ex  <= '0;
            next_instruction_20_16_id_ex <= '0;
            next_instruction_15_11_id_ex <= '0;
        end else begin
            ctrl_q                       <= (flush || hazard) ? ctrl_t'('0) : ctrl_dec;
            read_data_1_id_ex            <= rs_data;
            read_data_2_id_ex            <= rt_data;
            extended_branch_offset_id_ex <= imm_ext;
            supposed_next_address_id_ex  <= pc_plus4_if_id;
            next_instruction_20_16_id_ex <= rt;
            next_instruction_15_11_id_ex <= rd;
        end
    end

    assign ctrl_regDest_id_ex  = ctrl_q.reg_dest;
    assign ctrl_aluSrc_id_ex   = ctrl_q.alu_src;
    assign ctrl_aluOp_id_ex    = ctrl_q.alu_op;
    assign ctrl_branch_id_ex   = ctrl_q.branch;
    assign ctrl_memRead_id_ex  = ctrl_q.mem_read;
    assign ctrl_memWrite_id_ex = ctrl_q.mem_write;
    assign ctrl_memToReg_id_ex = ctrl_q.mem_to_reg;
    assign ctrl_regWrite_id_ex = ctrl_q.reg_write;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode of each opcode, WB bypass,
// load-use bubbles and flush priority, all against hand-computed values.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_if_id, pc_plus4_if_id, wb_write_data;
    logic        wb_reg_write, flush;
    logic [4:0]  wb_write_register;
    logic        stall_if;
    logic [31:0] read_data_1_id_ex, read_data_2_id_ex;
    logic [31:0] extended_branch_offset_id_ex, supposed_next_address_id_ex;
    logic [4:0]  next_instruction_20_16_id_ex, next_instruction_15_11_id_ex;
    logic        ctrl_regDest_id_ex, ctrl_aluSrc_id_ex, ctrl_branch_id_ex;
    logic [1:0]  ctrl_aluOp_id_ex;
    logic        ctrl_memRead_id_ex, ctrl_memWrite_id_ex, ctrl_memToReg_id_ex, ctrl_regWrite_id_ex;

    int checks = 0;
    int errors = 0;

    // {regDest, aluSrc, aluOp[1:0], branch, memRead, memWrite, memToReg, regWrite}
    localparam logic [8:0] C_R    = 9'b1_0_10_0_0_0_0_1;
    localparam logic [8:0] C_LW   = 9'b0_1_00_0_1_0_1_1;
    localparam logic [8:0] C_SW   = 9'b0_1_00_0_0_1_0_0;
    localparam logic [8:0] C_BEQ  = 9'b0_0_01_1_0_0_0_0;
    localparam logic [8:0] C_ADDI = 9'b0_1_00_0_0_0_0_1;
    localparam logic [8:0] C_NOP  = 9'b0;

    localparam logic [31:0] I_ADD_3_1_2  = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] I_ADD_3_7_8  = 32'h00E8_1820; // add  $3,$7,$8
    localparam logic [31:0] I_ADD_0_4_0  = 32'h0080_0020; // add  $0,$4,$0
    localparam logic [31:0] I_LW_5       = 32'h8C25_FFFC; // lw   $5,-4($1)
    localparam logic [31:0] I_LW_0       = 32'h8C20_0000; // lw   $0,0($1)
    localparam logic [31:0] I_ADD_6_5_1  = 32'h00A1_3020; // add  $6,$5,$1
    localparam logic [31:0] I_ADD_7_1_5  = 32'h0025_3820; // add  $7,$1,$5
    localparam logic [31:0] I_ADD_6_0_1  = 32'h0001_3020; // add  $6,$0,$1
    localparam logic [31:0] I_BEQ        = 32'h1022_0003; // beq  $1,$2,3
    localparam logic [31:0] I_SW         = 32'hAC25_0004; // sw   $5,4($1)
    localparam logic [31:0] I_ADDI       = 32'h2027_0010; // addi $7,$1,16
    localparam logic [31:0] I_BAD        = 32'hFC00_0000;

    decode_stage dut (
        .clk(clk), .reset(reset),
        .instruction_if_id(instruction_if_id), .pc_plus4_if_id(pc_plus4_if_id),
        .wb_reg_write(wb_reg_write), .wb_write_register(wb_write_register),
        .wb_write_data(wb_write_data), .flush(flush), .stall_if(stall_if),
        .read_data_1_id_ex(read_data_1_id_ex), .read_data_2_id_ex(read_data_2_id_ex),
        .extended_branch_offset_id_ex(extended_branch_offset_id_ex),
        .supposed_next_address_id_ex(supposed_next_address_id_ex),
        .next_instruction_20_16_id_ex(next_instruction_20_16_id_ex),
        .next_instruction_15_11_id_ex(next_instruction_15_11_id_ex),
        .ctrl_regDest_id_ex(ctrl_regDest_id_ex), .ctrl_aluSrc_id_ex(ctrl_aluSrc_id_ex),
        .ctrl_aluOp_id_ex(ctrl_aluOp_id_ex), .ctrl_branch_id_ex(ctrl_branch_id_ex),
        .ctrl_memRead_id_ex(ctrl_memRead_id_ex), .ctrl_memWrite_id_ex(ctrl_memWrite_id_ex),
        .ctrl_memToReg_id_ex(ctrl_memToReg_id_ex), .ctrl_regWrite_id_ex(ctrl_regWrite_id_ex)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ctrl_vec();
        return {ctrl_regDest_id_ex, ctrl_aluSrc_id_ex, ctrl_aluOp_id_ex, ctrl_branch_id_ex,
                ctrl_memRead_id_ex, ctrl_memWrite_id_ex, ctrl_memToReg_id_ex, ctrl_regWrite_id_ex};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        wb_reg_write = en; wb_write_register = r; wb_write_data = d;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; pc_plus4_if_id = 32'h0000_0100;
        instruction_if_id = I_ADD_3_7_8;
        wb(1'b1, 5'd7, 32'h1234_5678);
        tick();
        // 1: reset holds everything at zero, even with WB and a live instruction
        chk("rst_ctrl", {23'b0, ctrl_vec()}, {23'b0, C_NOP});
        chk("rst_rd1", read_data_1_id_ex, 32'h0);
        chk("rst_pc", supposed_next_address_id_ex, 32'h0);
        chk("rst_stall", {31'b0, stall_if}, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        reset = 1'b1;
        tick();
        chk("rst_rd_reg7", read_data_1_id_ex, 32'h0);
        chk("rst_rd_reg8", read_data_2_id_ex, 32'h0);

        // 2: R-type
        wb(1'b1, 5'd1, 32'd5); tick();
        wb(1'b1, 5'd2, 32'd7); tick();
        wb(1'b0, 5'd0, 32'h0);
        instruction_if_id = I_ADD_3_1_2; pc_plus4_if_id = 32'h0000_0204;
        tick();
        chk("r_rd1", read_data_1_id_ex, 32'd5);
        chk("r_rd2", read_data_2_id_ex, 32'd7);
        chk("r_rd", {27'b0, next_instruction_15_11_id_ex}, 32'd3);
        chk("r_rt", {27'b0, next_instruction_20_16_id_ex}, 32'd2);
        chk("r_ctrl", {23'b0, ctrl_vec()}, {23'b0, C_R});
        chk("r_pc", supposed_next_address_id_ex, 32'h0000_0204);
        chk("r_funct", {26'b0, extended_branch_offset_id_ex[5:0]}, 32'h20);

        // 3: same-cycle WB bypass, then registered value, then $0 immutability
        instruction_if_id = I_ADD_0_4_0;
        wb(1'b1, 5'd4, 32'hDEAD_BEEF);
        tick();
        chk("byp_rs", read_data_1_id_ex, 32'hDEAD_BEEF);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        chk("byp_stored", read_data_1_id_ex, 32'hDEAD_BEEF);
        instruction_if_id = 32'h0000_0020; // add $0,$0,$0
        wb(1'b1, 5'd0, 32'd9);
        tick();
        chk("zero_bypass", read_data_1_id_ex, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        chk("zero_stored", read_data_2_id_ex, 32'h0);

        // 4: lw with negative immediate
        instruction_if_id = I_LW_5;
        tick();
        chk("lw_ext", extended_branch_offset_id_ex, 32'hFFFF_FFFC);
        chk("lw_ctrl", {23'b0, ctrl_vec()}, {23'b0, C_LW});
        chk("lw_rt", {27'b0, next_instruction_20_16_id_ex}, 32'd5);

        // 5: load-use on rs: one stall, one bubble, then the add issues
        instruction_if_id = I_ADD_6_5_1; #1;
        chk("lu_stall", {31'b0, stall_if}, 32'h1);
        tick();
        chk("lu_bubble", {23'b0, ctrl_vec()}, {23'b0, C_NOP});
        chk("lu_stall_clr", {31'b0, stall_if}, 32'h0);
        tick();
        chk("lu_issue", {23'b0, ctrl_vec()}, {23'b0, C_R});
        chk("lu_rd", {27'b0, next_instruction_15_11_id_ex}, 32'd6);
        chk("lu_rd2", read_data_2_id_ex, 32'd5);

        // load-use through rt; lw to $0 never stalls
        instruction_if_id = I_LW_5; tick();
        instruction_if_id = I_ADD_7_1_5; #1;
        chk("lu_rt_stall", {31'b0, stall_if}, 32'h1);
        instruction_if_id = I_LW_0; tick();
        instruction_if_id = I_ADD_6_0_1; #1;
        chk("lw0_nostall", {31'b0, stall_if}, 32'h0);
        tick();
        chk("lw0_issue", {23'b0, ctrl_vec()}, {23'b0, C_R});

        // 6: flush squashes beq, then beq loads when flush drops
        instruction_if_id = I_BEQ; flush = 1'b1;
        tick();
        chk("fl_ctrl", {23'b0, ctrl_vec()}, {23'b0, C_NOP});
        flush = 1'b0;
        tick();
        chk("beq_ctrl", {23'b0, ctrl_vec()}, {23'b0, C_BEQ});
        chk("beq_ext", extended_branch_offset_id_ex, 32'h3);

        // flush together with hazard: single bubble, no second stall
        instruction_if_id = I_LW_5; tick();
        instruction_if_id = I_ADD_6_5_1; flush = 1'b1; #1;
        chk("flhz_stall", {31'b0, stall_if}, 32'h1);
        tick();
        chk("flhz_ctrl", {23'b0, ctrl_vec()}, {23'b0, C_NOP});
        chk("flhz_nostall", {31'b0, stall_if}, 32'h0);
        flush = 1'b0;
        tick();
        chk("flhz_issue", {23'b0, ctrl_vec()}, {23'b0, C_R});

        // remaining opcodes
        instruction_if_id = I_SW; tick();
        chk("sw_ctrl", {23'b0, ctrl_vec()}, {23'b0, C_SW});
        instruction_if_id = I_ADDI; tick();
        chk("addi_ctrl", {23'b0, ctrl_vec()}, {23'b0, C_ADDI});
        chk("addi_ext", extended_branch_offset_id_ex, 32'h10);
        instruction_if_id = I_BAD; tick();
        chk("bad_ctrl", {23'b0, ctrl_vec()}, {23'b0, C_NOP});

        // mid-operation async reset clears pipeline and regfile
        instruction_if_id = I_ADD_3_1_2; tick();
        #2 reset = 1'b0; #1;
        chk("mrst_ctrl", {23'b0, ctrl_vec()}, {23'b0, C_NOP});
        chk("mrst_rd1", read_data_1_id_ex, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("mrst_load", {23'b0, ctrl_vec()}, {23'b0, C_R});
        chk("mrst_reg1", read_data_1_id_ex, 32'h0);
        chk("mrst_reg2", read_data_2_id_ex, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
